// File: rtl/dmem_responder_pkg.sv
// Shared types, widths and helpers for the data-memory responder.
// Optional alignment checking is enabled with DMEM_RESPONDER_ALIGN_CHECK_EN.
`ifndef DWIDTH
`define DWIDTH 32
`endif

package dmem_responder_pkg;

  localparam int unsigned DATA_W = `DWIDTH;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Request fields captured at the accept edge
  typedef struct packed {
    logic              wr_en;
    logic              err;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } req_t;

  // Byte, aligned half-word or aligned word patterns for byte offset a
  function automatic logic mask_aligned(input logic [1:0] a, input logic [MASK_W-1:0] m);
    logic ok;
    ok = 1'b0;
    case (m)
      4'b0001: ok = (a == 2'd0);
      4'b0010: ok = (a == 2'd1);
      4'b0100: ok = (a == 2'd2);
      4'b1000: ok = (a == 2'd3);
      4'b0011: ok = (a == 2'd0);
      4'b1100: ok = (a == 2'd2);
      4'b1111: ok = (a == 2'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// DEPTH x 32 word array with per-byte write enables and a registered read port.
`ifndef DWIDTH
`define DWIDTH 32
`endif

module dmem_byte_ram
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 en_i,
  input  logic [MASK_W-1:0]    we_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  output logic [DATA_W-1:0]    rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read returns the pre-write word; the responder zeroes store responses anyway
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      for (int i = 0; i < int'(MASK_W); i++) begin
        if (we_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store target with fixed access latency and valid/ready request and response channels.
// Define DMEM_RESPONDER_ALIGN_CHECK_EN to add dr_o_rsp_err and misalignment rejection.
`ifndef DWIDTH
`define DWIDTH 32
`endif

module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic               dr_clk,
  input  logic               dr_rst,
  input  logic               dr_i_req_valid,
  output logic               dr_o_req_ready,
  input  logic               dr_i_wr_en,
  input  logic [`DWIDTH-1:0] dr_i_addr,
  input  logic [3:0]         dr_i_mask,
  input  logic [`DWIDTH-1:0] dr_i_store_data,
  output logic               dr_o_rsp_valid,
  input  logic               dr_i_rsp_ready,
  output logic [`DWIDTH-1:0] dr_o_load_data,
  output logic               dr_o_busy
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
  ,output logic              dr_o_rsp_err
`endif
);

  localparam int unsigned ADDR_BITS = $clog2(DEPTH);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  req_t                 req_q, req_d;
  logic [ADDR_BITS-1:0] widx_q, widx_d;
  logic                 ready_q, rsp_valid_q, busy_q;
  logic                 access_c;
  logic [DATA_W-1:0]    rd_data;
  logic                 unused_addr_bits;

  // Offset bits and bits above the array size are ignored (address wraps)
  assign unused_addr_bits = ^dr_i_addr;

  assign dr_o_req_ready = ready_q & ~dr_rst;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    widx_d   = widx_q;
    access_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dr_i_req_valid && dr_o_req_ready) begin
          req_d.wr_en = dr_i_wr_en;
          req_d.mask  = dr_i_mask;
          req_d.data  = dr_i_store_data;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
          req_d.err   = dr_i_wr_en ? !mask_aligned(dr_i_addr[1:0], dr_i_mask)
                                   : (dr_i_addr[1:0] != 2'd0);
`else
          req_d.err   = 1'b0;
`endif
          widx_d  = dr_i_addr[ADDR_BITS+1:2];
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          access_c = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (dr_i_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge dr_clk) begin
    if (dr_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      widx_q      <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      widx_q      <= widx_d;
      ready_q     <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  // A reset on the access edge cancels the write
  dmem_byte_ram #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk_i   (dr_clk),
    .en_i    (access_c & ~dr_rst),
    .we_i    ((access_c && !dr_rst && req_q.wr_en && !req_q.err) ? req_q.mask : '0),
    .addr_i  (widx_q),
    .wdata_i (req_q.data),
    .rdata_o (rd_data)
  );

  assign dr_o_rsp_valid = rsp_valid_q;
  assign dr_o_busy      = busy_q;
  assign dr_o_load_data = (rsp_valid_q && !req_q.wr_en && !req_q.err) ? rd_data : '0;

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
  assign dr_o_rsp_err = rsp_valid_q & req_q.err;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=1024, LATENCY=2).
// Also exercises dr_o_rsp_err when DMEM_RESPONDER_ALIGN_CHECK_EN is defined.
`timescale 1ns/1ps

module tb_dmem_responder;

  localparam int LATENCY = 2;

  logic        dr_clk;
  logic        dr_rst;
  logic        dr_i_req_valid;
  logic        dr_o_req_ready;
  logic        dr_i_wr_en;
  logic [31:0] dr_i_addr;
  logic [3:0]  dr_i_mask;
  logic [31:0] dr_i_store_data;
  logic        dr_o_rsp_valid;
  logic        dr_i_rsp_ready;
  logic [31:0] dr_o_load_data;
  logic        dr_o_busy;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
  logic        dr_o_rsp_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  dmem_responder #(
    .DEPTH   (1024),
    .LATENCY (LATENCY)
  ) dut (
    .dr_clk          (dr_clk),
    .dr_rst          (dr_rst),
    .dr_i_req_valid  (dr_i_req_valid),
    .dr_o_req_ready  (dr_o_req_ready),
    .dr_i_wr_en      (dr_i_wr_en),
    .dr_i_addr       (dr_i_addr),
    .dr_i_mask       (dr_i_mask),
    .dr_i_store_data (dr_i_store_data),
    .dr_o_rsp_valid  (dr_o_rsp_valid),
    .dr_i_rsp_ready  (dr_i_rsp_ready),
    .dr_o_load_data  (dr_o_load_data),
    .dr_o_busy       (dr_o_busy)
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    ,.dr_o_rsp_err   (dr_o_rsp_err)
`endif
  );

  initial dr_clk = 1'b0;
  always #5 dr_clk = ~dr_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge dr_clk);
    #1;
  endtask

  // Wait for rsp_valid, returning the number of cycles waited
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!dr_o_rsp_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  // Full transaction: accept, latency check, optional back-pressure hold, handshake
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input int hold,
                        output logic [31:0] ld, output logic err);
    int guard;
    int cyc;
    logic [31:0] first;
    dr_i_req_valid  = 1'b1;
    dr_i_wr_en      = wr;
    dr_i_addr       = addr;
    dr_i_mask       = mask;
    dr_i_store_data = data;
    guard = 0;
    while (!dr_o_req_ready && guard < 20) begin
      tick();
      guard++;
    end
    check("req_ready_idle", 32'(dr_o_req_ready), 32'd1);
    tick();
    dr_i_req_valid  = 1'b0;
    dr_i_wr_en      = ~wr;
    dr_i_addr       = 32'hFFFF_FFFC;
    dr_i_mask       = ~mask;
    dr_i_store_data = ~data;
    wait_rsp(cyc);
    check("latency", 32'(cyc), 32'(LATENCY));
    first = dr_o_load_data;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 32'(dr_o_rsp_valid), 32'd1);
      check("hold_data", dr_o_load_data, first);
      check("hold_ready", 32'(dr_o_req_ready), 32'd0);
    end
    ld = dr_o_load_data;
`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    err = dr_o_rsp_err;
`else
    err = 1'b0;
`endif
    dr_i_rsp_ready = 1'b1;
    tick();
    dr_i_rsp_ready = 1'b0;
    check("rsp_drop", 32'(dr_o_rsp_valid), 32'd0);
    check("ready_after", 32'(dr_o_req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ld;
    logic        err;
    int          cyc;

    dr_rst          = 1'b1;
    dr_i_req_valid  = 1'b0;
    dr_i_wr_en      = 1'b0;
    dr_i_addr       = '0;
    dr_i_mask       = '0;
    dr_i_store_data = '0;
    dr_i_rsp_ready  = 1'b0;
    tick();
    tick();
    check("rst_ready", 32'(dr_o_req_ready), 32'd0);
    check("rst_valid", 32'(dr_o_rsp_valid), 32'd0);
    check("rst_busy", 32'(dr_o_busy), 32'd0);
    check("rst_data", dr_o_load_data, 32'd0);
    dr_rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(dr_o_req_ready), 32'd1);

    // Full-word store then load
    do_req(1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF, 0, ld, err);
    check("st_full_data", ld, 32'd0);
    do_req(1'b0, 32'h10, 4'b0000, 32'h0, 0, ld, err);
    check("ld_full", ld, 32'hDEAD_BEEF);

    // Byte store, then empty-mask store
    do_req(1'b1, 32'h10, 4'b0001, 32'h0000_00AA, 0, ld, err);
    check("st_byte_data", ld, 32'd0);
    do_req(1'b0, 32'h10, 4'b1111, 32'h0, 0, ld, err);
    check("ld_byte", ld, 32'hDEAD_BEAA);
    do_req(1'b1, 32'h10, 4'b0000, 32'h1122_3344, 0, ld, err);
    check("st_nomask_data", ld, 32'd0);

    // Back-pressure for 5 cycles
    do_req(1'b0, 32'h10, 4'b0000, 32'h0, 5, ld, err);
    check("ld_backpressure", ld, 32'hDEAD_BEAA);

    // Address wrap modulo DEPTH*4
    do_req(1'b1, 32'h1004, 4'b1111, 32'h1234_5678, 0, ld, err);
    do_req(1'b0, 32'h0004, 4'b0000, 32'h0, 0, ld, err);
    check("ld_wrap", ld, 32'h1234_5678);
`ifndef DMEM_RESPONDER_ALIGN_CHECK_EN
    do_req(1'b0, 32'h1007, 4'b0000, 32'h0, 0, ld, err);
    check("ld_offset_ignored", ld, 32'h1234_5678);
`endif

    // Reset in WAIT drops the store
    do_req(1'b1, 32'h20, 4'b1111, 32'hCAFE_F00D, 0, ld, err);
    dr_i_req_valid  = 1'b1;
    dr_i_wr_en      = 1'b1;
    dr_i_addr       = 32'h20;
    dr_i_mask       = 4'b1111;
    dr_i_store_data = 32'h5555_5555;
    tick();
    dr_i_req_valid = 1'b0;
    check("wait_busy", 32'(dr_o_busy), 32'd1);
    dr_rst = 1'b1;
    tick();
    check("rst_wait_valid", 32'(dr_o_rsp_valid), 32'd0);
    check("rst_wait_busy", 32'(dr_o_busy), 32'd0);
    check("rst_wait_ready", 32'(dr_o_req_ready), 32'd0);
    dr_rst = 1'b0;
    tick();
    tick();
    check("rst_no_rsp", 32'(dr_o_rsp_valid), 32'd0);
    do_req(1'b0, 32'h20, 4'b0000, 32'h0, 0, ld, err);
    check("ld_after_rst", ld, 32'hCAFE_F00D);

    // New request during the response handshake is held off one cycle
    dr_i_req_valid = 1'b1;
    dr_i_wr_en     = 1'b0;
    dr_i_addr      = 32'h10;
    tick();
    dr_i_req_valid = 1'b0;
    wait_rsp(cyc);
    check("ovl_latency", 32'(cyc), 32'(LATENCY));
    check("ovl_first", dr_o_load_data, 32'hDEAD_BEAA);
    dr_i_req_valid = 1'b1;
    dr_i_addr      = 32'h4;
    dr_i_rsp_ready = 1'b1;
    #1;
    check("ovl_ready_resp", 32'(dr_o_req_ready), 32'd0);
    tick();
    dr_i_rsp_ready = 1'b0;
    check("ovl_idle_busy", 32'(dr_o_busy), 32'd0);
    check("ovl_idle_ready", 32'(dr_o_req_ready), 32'd1);
    tick();
    dr_i_req_valid = 1'b0;
    check("ovl_accept_busy", 32'(dr_o_busy), 32'd1);
    wait_rsp(cyc);
    check("ovl_second", dr_o_load_data, 32'h1234_5678);
    dr_i_rsp_ready = 1'b1;
    tick();
    dr_i_rsp_ready = 1'b0;

`ifdef DMEM_RESPONDER_ALIGN_CHECK_EN
    do_req(1'b0, 32'h21, 4'b0000, 32'h0, 0, ld, err);
    check("al_ld_err", 32'(err), 32'd1);
    check("al_ld_data", ld, 32'd0);
    do_req(1'b1, 32'h22, 4'b1100, 32'hBEEF_0000, 0, ld, err);
    check("al_st_ok", 32'(err), 32'd0);
    do_req(1'b1, 32'h21, 4'b0110, 32'h0011_2200, 0, ld, err);
    check("al_st_err", 32'(err), 32'd1);
    do_req(1'b0, 32'h20, 4'b0000, 32'h0, 0, ld, err);
    check("al_ld_half", ld, 32'hBEEF_F00D);
    check("al_ld_half_err", 32'(err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
